// File: rtl/fetch_queue_if.sv
// Fetch front-end buses: instruction-cache read port (0a stage) and the decode drain handshake.
// The master side is the fetch queue; the slave side is the cache plus decode.
interface fetch_queue_if;
  logic [31:0] ic__rd_addr_0a;
  logic        ic__rd_req_0a;
  logic        ic__rd_wait_0a;
  logic [31:0] ic__rd_data_0a;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_insn;
  logic [31:0] fq_pc;

  modport master (
    output ic__rd_addr_0a,
    output ic__rd_req_0a,
    input  ic__rd_wait_0a,
    input  ic__rd_data_0a,
    output fq_valid,
    input  fq_ready,
    output fq_insn,
    output fq_pc
  );

  modport slave (
    input  ic__rd_addr_0a,
    input  ic__rd_req_0a,
    output ic__rd_wait_0a,
    output ic__rd_data_0a,
    input  fq_valid,
    output fq_ready,
    input  fq_insn,
    input  fq_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: holds the fetch PC, reads one word per cycle from the I-cache and
// buffers {pc, insn} pairs in a small FIFO drained by decode; a redirect flushes and restarts fetch.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          jmp,
  input  logic [31:0]   jmp_pc,
  fetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      insn_mem [DEPTH];

  logic req;
  logic push;
  logic pop;
  logic head_vld;

  // Request is built only from registered state, jmp and reset, so decode backpressure never
  // reaches the cache address path.
  always_comb begin
    req      = rst_b && !jmp && (count != CNT_FULL);
    push     = req && !bus.ic__rd_wait_0a;
    head_vld = (count != '0) && !jmp;
    pop      = head_vld && bus.fq_ready;
  end

  assign bus.ic__rd_req_0a  = req;
  assign bus.ic__rd_addr_0a = pc;
  assign bus.fq_valid       = head_vld;
  assign bus.fq_insn        = head_vld ? insn_mem[rd_ptr] : '0;
  assign bus.fq_pc          = head_vld ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (jmp) begin
      pc     <= jmp_pc & 32'hFFFF_FFFC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage holds data only; entries beyond count are never presented, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      insn_mem[wr_ptr] <= bus.ic__rd_data_0a;
    end
  end

endmodule
